// File: rtl/fetcher_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, FSM encoding,
// BHT counter reset value and immediate extraction helpers.
package fetcher_pkg;

    typedef logic [31:0] data_t;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    localparam logic [1:0] BHT_RESET = 2'b01;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    function automatic data_t imm_j(input data_t i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic data_t imm_b(input data_t i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetcher_bht.sv
// Branch history table: 2^BHT_BITS saturating 2-bit counters with a
// combinational lookup and a synchronous, rdy-gated update port.
module fetcher_bht
    import fetcher_pkg::*;
#(
    parameter int BHT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [BHT_BITS-1:0] lookup_idx,
    output logic                lookup_taken,
    input  logic                update_valid,
    input  logic [BHT_BITS-1:0] update_idx,
    input  logic                update_taken
);

    localparam int ENTRIES = 2 ** BHT_BITS;

    logic [1:0] counters [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0] count_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_reg <= BHT_RESET;
                end else if (rdy && update_valid && update_idx == BHT_BITS'(gi)) begin
                    if (update_taken && count_reg != 2'b11) begin
                        count_reg <= count_reg + 2'b01;
                    end else if (!update_taken && count_reg != 2'b00) begin
                        count_reg <= count_reg - 2'b01;
                    end
                end
            end

            assign counters[gi] = count_reg;
        end
    endgenerate

    // Lookup sees the pre-update value when read and write hit the same entry.
    assign lookup_taken = counters[lookup_idx][1];

endmodule

// File: rtl/fetcher.sv
// Instruction fetch unit: requests words from memory, buffers one, hands it
// to the decoder for a single cycle and predicts the next PC (JAL + BHT).
module fetcher
    import fetcher_pkg::*;
#(
    parameter int BHT_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        out_mem_valid,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_done,
    input  logic [31:0] in_mem_instr,
    input  logic        in_rob_full,
    input  logic        in_rs_full,
    input  logic        in_lsb_full,
    output logic [31:0] out_dec_instr,
    output logic [31:0] out_dec_pc,
    output logic        out_dec_jump_flag,
    input  logic        in_rob_clear,
    input  logic [31:0] in_rob_new_pc,
    input  logic        in_rob_bht_valid,
    input  logic [31:0] in_rob_bht_pc,
    input  logic        in_rob_bht_taken
);

    logic [1:0] state_reg;
    data_t      pc_reg;
    data_t      buf_instr_reg;
    data_t      buf_pc_reg;
    data_t      stale_addr_reg;

    logic       bht_taken;
    logic       pred_taken;
    data_t      next_pc;
    logic       stall;
    logic       unused_bht_pc_bits;

    fetcher_bht #(
        .BHT_BITS (BHT_BITS)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .lookup_idx   (buf_pc_reg[BHT_BITS+1:2]),
        .lookup_taken (bht_taken),
        .update_valid (in_rob_bht_valid),
        .update_idx   (in_rob_bht_pc[BHT_BITS+1:2]),
        .update_taken (in_rob_bht_taken)
    );

    assign unused_bht_pc_bits = ^{in_rob_bht_pc[31:BHT_BITS+2], in_rob_bht_pc[1:0]};

    always_comb begin
        pred_taken = 1'b0;
        next_pc    = buf_pc_reg + 32'd4;
        if (buf_instr_reg[6:0] == OPCODE_JAL) begin
            pred_taken = 1'b1;
            next_pc    = buf_pc_reg + imm_j(buf_instr_reg);
        end else if (buf_instr_reg[6:0] == OPCODE_BRANCH && bht_taken) begin
            pred_taken = 1'b1;
            next_pc    = buf_pc_reg + imm_b(buf_instr_reg);
        end
    end

    assign stall = in_rob_full | in_rs_full | in_lsb_full;

    // A flushed request keeps its original address until memory answers it.
    assign out_mem_valid = (state_reg != ST_PEND);
    assign out_mem_addr  = (state_reg == ST_FLUSH) ? stale_addr_reg : pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= ST_FETCH;
            pc_reg            <= '0;
            buf_instr_reg     <= '0;
            buf_pc_reg        <= '0;
            stale_addr_reg    <= '0;
            out_dec_instr     <= '0;
            out_dec_pc        <= '0;
            out_dec_jump_flag <= 1'b0;
        end else if (rdy) begin
            out_dec_instr <= '0;
            if (in_rob_clear) begin
                pc_reg <= in_rob_new_pc;
                if (state_reg == ST_FETCH && !in_mem_done) begin
                    state_reg      <= ST_FLUSH;
                    stale_addr_reg <= pc_reg;
                end else if (state_reg != ST_FLUSH) begin
                    state_reg <= ST_FETCH;
                end
            end else begin
                case (state_reg)
                    ST_FETCH: begin
                        if (in_mem_done) begin
                            buf_instr_reg <= in_mem_instr;
                            buf_pc_reg    <= pc_reg;
                            state_reg     <= ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        if (!stall) begin
                            out_dec_instr     <= buf_instr_reg;
                            out_dec_pc        <= buf_pc_reg;
                            out_dec_jump_flag <= pred_taken;
                            pc_reg            <= next_pc;
                            state_reg         <= ST_FETCH;
                        end
                    end
                    ST_FLUSH: begin
                        if (in_mem_done) begin
                            state_reg <= ST_FETCH;
                        end
                    end
                    default: state_reg <= ST_FETCH;
                endcase
            end
        end
    end

endmodule
